fetch_pc_ctrl: RTL

- Next-generation program counter for the instruction-fetch stage. Holds the architectural fetch PC and issues one outstanding fetch request to instruction memory through a valid/ready handshake.
- Captures each response into a one-entry output buffer for decode.
- Applies branch-predictor and branch-resolution redirects.
- Discards responses made stale by a redirect.

---
 rtl/fetch_pc_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch PC controller: one outstanding fetch request, a one-entry
// decode buffer, predictor/resolution redirects and stale-response discard.
module fetch_pc_ctrl #(
    parameter int unsigned    LEN        = 32,
    parameter logic [LEN-1:0] RESET_PC   = '0,
    parameter int unsigned    INST_BYTES = 4,
    parameter int unsigned    CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy_in,
    input  logic             redirect_valid,
    input  logic [LEN-1:0]   redirect_target,
    output logic             req_valid,
    output logic [LEN-1:0]   req_addr,
    input  logic             req_ready,
    input  logic             resp_valid,
    input  logic [LEN-1:0]   resp_inst,
    input  logic             pred_taken,
    input  logic [LEN-1:0]   pred_target,
    output logic             inst_valid,
    output logic [LEN-1:0]   inst_out,
    output logic [LEN-1:0]   inst_pc,
    input  logic             inst_ready,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [LEN-1:0]   PC_STEP = LEN'(INST_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [LEN-1:0]   pc_q, pc_d;
    logic             inst_valid_q, inst_valid_d;
    logic [LEN-1:0]   inst_out_q, inst_out_d;
    logic [LEN-1:0]   inst_pc_q, inst_pc_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             accept;

    // State and datapath registers; reset wins over the global enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_out_q   <= '0;
            inst_pc_q    <= '0;
            fetch_cnt_q  <= '0;
            drop_cnt_q   <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            fetch_cnt_q  <= fetch_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Next state: redirect beats response, response beats sequential step.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        fetch_cnt_d  = fetch_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        accept       = req_valid && req_ready;

        if (inst_valid_q && inst_ready) begin
            inst_valid_d = 1'b0;
        end

        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = accept ? S_DROP : S_REQ;
                end else if (accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid && resp_valid) begin
                    drop_cnt_d = drop_cnt_q + CNT_ONE;
                    pc_d       = redirect_target;
                    state_d    = S_REQ;
                end else if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = S_DROP;
                end else if (resp_valid) begin
                    inst_out_d   = resp_inst;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    fetch_cnt_d  = fetch_cnt_q + CNT_ONE;
                    pc_d         = pred_taken ? pred_target : pc_q + PC_STEP;
                    state_d      = S_REQ;
                end
            end
            S_DROP: begin
                if (resp_valid) begin
                    drop_cnt_d = drop_cnt_q + CNT_ONE;
                    state_d    = S_REQ;
                end
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // A redirect flushes the buffer, overriding any fill on this edge.
        if (redirect_valid) begin
            inst_valid_d = 1'b0;
        end
    end

    // Outputs: request only from S_REQ with an empty buffer.
    always_comb begin
        req_valid  = (state_q == S_REQ) && !inst_valid_q;
        req_addr   = pc_q;
        inst_valid = inst_valid_q;
        inst_out   = inst_out_q;
        inst_pc    = inst_pc_q;
        fetch_cnt  = fetch_cnt_q;
        drop_cnt   = drop_cnt_q;
    end

endmodule
